// File: rtl/layer_sequencer.sv
// layer_sequencer
// Collects the parallel per-neuron results of one fully-connected layer and
// then streams them, one per cycle, into the serial input of the next layer.
// New results are held off until the downstream layer reports completion;
// any result arriving while busy is dropped and raises a sticky overrun flag.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   in_valid   per-lane result-valid pulses (NUM_NEURONS bits)
//   in_data    packed lane results, lane i at [i*DATAWIDTH +: DATAWIDTH]
//   ds_done    downstream frame-consumed pulse (only honoured in HOLD)
//   out_data   serial value to downstream input_val
//   out_valid  qualifier to downstream input_valid
//   busy       high whenever the sequencer is not collecting
//   overrun    sticky: a result arrived while busy
//   frame_cnt  frames streamed, wraps at 255
//
// Optional build macro ARGMAX_EN adds:
//   class_idx    index of the largest (signed) streamed value, lower index on tie
//   class_valid  one-cycle pulse on the edge after the last out_valid
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | capturing lane results until every lane has been seen
// STREAM  | presenting cap[0..NUM_NEURONS-1] on consecutive cycles
// HOLD    | frame sent, waiting for ds_done from the downstream layer

module layer_sequencer #(
  parameter int NUM_NEURONS = 10,
  parameter int DATAWIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_NEURONS-1:0]           in_valid,
  input  logic [DATAWIDTH*NUM_NEURONS-1:0] in_data,
  input  logic                             ds_done,
  output logic [DATAWIDTH-1:0]             out_data,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             overrun,
  output logic [7:0]                       frame_cnt
`ifdef ARGMAX_EN
  ,
  output logic [$clog2(NUM_NEURONS)-1:0]   class_idx,
  output logic                             class_valid
`endif
);

  localparam int IDXW = $clog2(NUM_NEURONS);
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    STREAM  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATAWIDTH-1:0]   cap_q [NUM_NEURONS];
  logic [DATAWIDTH-1:0]   cap_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] got_q, got_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [DATAWIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    got_d       = got_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      COLLECT: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (in_valid[i]) begin
            cap_d[i] = in_data[i*DATAWIDTH +: DATAWIDTH];
            got_d[i] = 1'b1;
          end
        end
        if (&(got_q | in_valid)) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end

      STREAM: begin
        out_valid_d = 1'b1;
        out_data_d  = cap_q[idx_q];
        idx_d       = idx_q + 1'b1;
        if (|in_valid) overrun_d = 1'b1;
        if (idx_q == LAST) begin
          state_d     = HOLD;
          frame_cnt_d = frame_cnt_q + 8'd1;
          got_d       = '0;
          idx_d       = '0;
        end
      end

      HOLD: begin
        if (ds_done) begin
          // Results landing with ds_done belong to the next frame.
          state_d = COLLECT;
          for (int i = 0; i < NUM_NEURONS; i++) begin
            if (in_valid[i]) begin
              cap_d[i] = in_data[i*DATAWIDTH +: DATAWIDTH];
              got_d[i] = 1'b1;
            end
          end
        end else if (|in_valid) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = COLLECT;
    endcase

    busy_d = (state_d != COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      for (int i = 0; i < NUM_NEURONS; i++) cap_q[i] <= '0;
      got_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      got_q       <= got_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

`ifdef ARGMAX_EN
  logic signed [DATAWIDTH-1:0] max_q, max_d;
  logic [IDXW-1:0]             best_q, best_d;
  logic                        pend_q, pend_d;
  logic [IDXW-1:0]             class_idx_q, class_idx_d;
  logic                        class_valid_q, class_valid_d;

  // Running max follows the stream; strict '>' keeps the lower index on ties.
  always_comb begin
    max_d         = max_q;
    best_d        = best_q;
    pend_d        = 1'b0;
    class_idx_d   = class_idx_q;
    class_valid_d = pend_q;

    if (state_q == STREAM) begin
      if (idx_q == '0 || $signed(cap_q[idx_q]) > max_q) begin
        max_d  = $signed(cap_q[idx_q]);
        best_d = idx_q;
      end
      if (idx_q == LAST) pend_d = 1'b1;
    end

    if (pend_q) class_idx_d = best_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q         <= '0;
      best_q        <= '0;
      pend_q        <= 1'b0;
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      max_q         <= max_d;
      best_q        <= best_d;
      pend_q        <= pend_d;
      class_idx_q   <= class_idx_d;
      class_valid_q <= class_valid_d;
    end
  end

  assign class_idx   = class_idx_q;
  assign class_valid = class_valid_q;
`endif

endmodule
